// File: rtl/frog_game_pkg.sv
// rtl/frog_game_pkg.sv - shared types and constants for the frog game spawn logic
package frog_game_pkg;

  // Object length code carried with each spawn descriptor
  typedef enum logic [1:0] {
    LEN_SHORT  = 2'd0,
    LEN_MEDIUM = 2'd1,
    LEN_LONG   = 2'd2,
    LEN_XLONG  = 2'd3
  } spawn_len_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } sched_state_e;

  localparam int         TICK_DIV_DEF = 50000;
  localparam int         MIN_GAP_DEF  = 16;
  localparam logic [7:0] GAP_MASK_DEF = 8'h3F;

  // Clamp a non-negative sum into an 8-bit timer value
  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/frog_spawn_scheduler_if.sv
// rtl/frog_spawn_scheduler_if.sv - spawn descriptor handshake between scheduler and lane logic
interface frog_spawn_scheduler_if
  import frog_game_pkg::*;
#(
  parameter int LANE_W = 2
);
  logic              spawn_valid;
  logic              spawn_ready;
  logic [LANE_W-1:0] spawn_lane;
  logic              spawn_dir;
  spawn_len_e        spawn_len;

  modport master (
    output spawn_valid, spawn_lane, spawn_dir, spawn_len,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_lane, spawn_dir, spawn_len,
    output spawn_ready
  );
endinterface

// File: rtl/frog_spawn_scheduler_rr_pick.sv
// rtl/frog_spawn_scheduler_rr_pick.sv - combinational round-robin picker starting after last_grant
module rr_pick #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0] pending,
  input  logic [LANE_W-1:0]    last_grant,
  output logic [LANE_W-1:0]    grant,
  output logic                 found
);

  // Walk the lanes from last_grant+1 with wraparound and keep the first requester
  always_comb begin
    logic [LANE_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = last_grant;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = (idx == LANE_W'(NUM_LANES - 1)) ? '0 : idx + LANE_W'(1);
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/frog_spawn_scheduler.sv
// rtl/frog_spawn_scheduler.sv - per-lane gap timers and round-robin spawn descriptor issue
module frog_spawn_scheduler
  import frog_game_pkg::*;
#(
  parameter int         NUM_LANES = 4,
  parameter int         LANE_W    = 2,
  parameter int         TICK_DIV  = TICK_DIV_DEF,
  parameter int         MIN_GAP   = MIN_GAP_DEF,
  parameter logic [7:0] GAP_MASK  = GAP_MASK_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [13:0]            rnd_in,
  frog_spawn_scheduler_if.master spawn,
  output logic [NUM_LANES-1:0]   pending
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  sched_state_e      state;
  logic [PW-1:0]     presc;
  logic              tick;
  logic [7:0]        timer [NUM_LANES];
  logic [7:0]        gap;
  logic [LANE_W-1:0] last_grant;
  logic [LANE_W-1:0] grant;
  logic              found;
  logic              accept;
  logic              unused_rnd;

  assign tick       = run && (presc == PW'(TICK_DIV - 1));
  assign accept     = spawn.spawn_valid && spawn.spawn_ready;
  assign unused_rnd = ^rnd_in[13:10];

  rr_pick #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_rr_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (grant),
    .found      (found)
  );

  // Game-tick prescaler; frozen while the game is paused
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (run) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Lane timers, pending flags and the IDLE/OFFER descriptor handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      spawn.spawn_valid <= 1'b0;
      spawn.spawn_lane  <= '0;
      spawn.spawn_dir   <= 1'b0;
      spawn.spawn_len   <= LEN_SHORT;
      pending           <= '0;
      gap               <= '0;
      last_grant        <= LANE_W'(NUM_LANES - 1);
      for (int i = 0; i < NUM_LANES; i++) begin
        timer[i] <= sat8(MIN_GAP + 4 * i);
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        // The served lane reloads its gap even if a tick lands in the same cycle
        if (accept && (spawn.spawn_lane == LANE_W'(i))) begin
          timer[i]   <= gap;
          pending[i] <= 1'b0;
        end else begin
          if (tick && (timer[i] != 8'd0)) begin
            timer[i] <= timer[i] - 8'd1;
          end
          if (timer[i] == 8'd0) begin
            pending[i] <= 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (found) begin
            spawn.spawn_lane  <= grant;
            spawn.spawn_dir   <= grant[0];
            spawn.spawn_len   <= spawn_len_e'(rnd_in[9:8]);
            gap               <= sat8(MIN_GAP + int'(rnd_in[7:0] & GAP_MASK));
            spawn.spawn_valid <= 1'b1;
            state             <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (accept) begin
            spawn.spawn_valid <= 1'b0;
            last_grant        <= spawn.spawn_lane;
            state             <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frog_spawn_scheduler.sv
// tb/tb_frog_spawn_scheduler.sv - directed bench for the frog spawn scheduler and its round-robin picker
module tb_frog_spawn_scheduler;
  import frog_game_pkg::*;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, run_a, run_b;
  logic [13:0] rnd_a, rnd_b;
  logic [3:0]  pend_a, pend_b;
  int          checks = 0;
  int          failures = 0;
  int          acc_a = 0;

  logic [3:0]  rr_pend;
  logic [1:0]  rr_last, rr_grant;
  logic        rr_found;

  typedef struct {
    logic [3:0] pend;
    logic [1:0] last;
    logic [1:0] grant;
    logic       found;
  } rr_vec_t;
  rr_vec_t vecs [9];

  frog_spawn_scheduler_if #(.LANE_W(2)) ifa ();
  frog_spawn_scheduler_if #(.LANE_W(2)) ifb ();

  frog_spawn_scheduler #(
    .NUM_LANES(4), .LANE_W(2), .TICK_DIV(2), .MIN_GAP(16), .GAP_MASK(8'h3F)
  ) u_a (
    .clk(clk), .rst(rst_a), .run(run_a), .rnd_in(rnd_a), .spawn(ifa.master), .pending(pend_a)
  );

  frog_spawn_scheduler #(
    .NUM_LANES(4), .LANE_W(2), .TICK_DIV(2), .MIN_GAP(250), .GAP_MASK(8'hFF)
  ) u_b (
    .clk(clk), .rst(rst_b), .run(run_b), .rnd_in(rnd_b), .spawn(ifb.master), .pending(pend_b)
  );

  rr_pick #(.NUM_LANES(4), .LANE_W(2)) u_rr (
    .pending(rr_pend), .last_grant(rr_last), .grant(rr_grant), .found(rr_found)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifa.spawn_valid && ifa.spawn_ready) acc_a <= acc_a + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic seq_a();
    int n;
    int t0, p0, acc0;
    int lane0, dir0, len0;

    n = 0;
    while (!ifa.spawn_valid && n < 200) begin step(); n++; end
    chk("first_spawn_latency", n, 34);
    chk("first_lane", int'(ifa.spawn_lane), 0);
    chk("first_dir", int'(ifa.spawn_dir), 0);
    chk("first_len", int'(ifa.spawn_len), 1);
    chk("first_pending", int'(pend_a), 4'b0001);
    step();
    chk("first_accept_valid", int'(ifa.spawn_valid), 0);
    chk("first_reload_timer0", int'(u_a.timer[0]), 21);
    chk("first_pending_clear", int'(pend_a), 0);

    ifa.spawn_ready = 1'b0;
    n = 0;
    while (!ifa.spawn_valid && n < 100) begin step(); n++; end
    chk("bp_offer_seen", int'(ifa.spawn_valid), 1);
    chk("bp_lane", int'(ifa.spawn_lane), 1);
    chk("bp_dir", int'(ifa.spawn_dir), 1);
    lane0 = int'(ifa.spawn_lane);
    dir0 = int'(ifa.spawn_dir);
    len0 = int'(ifa.spawn_len);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) run_a = 1'b0;
      if (i == 15) run_a = 1'b1;
      step();
      chk("bp_hold_valid", int'(ifa.spawn_valid), 1);
      chk("bp_hold_lane", int'(ifa.spawn_lane), lane0);
      chk("bp_hold_dir", int'(ifa.spawn_dir), dir0);
      chk("bp_hold_len", int'(ifa.spawn_len), len0);
    end
    chk("bp_pending_lane1", int'(pend_a[1]), 1);
    acc0 = acc_a;
    ifa.spawn_ready = 1'b1;
    step();
    ifa.spawn_ready = 1'b0;
    chk("bp_release_valid", int'(ifa.spawn_valid), 0);
    chk("bp_release_pending1", int'(pend_a[1]), 0);
    step(); step(); step();
    chk("bp_single_accept", acc_a - acc0, 1);
    chk("bp_next_offer_up", int'(ifa.spawn_valid), 1);
    chk("bp_next_offer_lane", int'(ifa.spawn_lane), 2);

    acc0 = acc_a;
    rst_a = 1'b1;
    step();
    chk("rst_offer_valid", int'(ifa.spawn_valid), 0);
    chk("rst_offer_pending", int'(pend_a), 0);
    chk("rst_offer_t0", int'(u_a.timer[0]), 16);
    chk("rst_offer_t1", int'(u_a.timer[1]), 20);
    chk("rst_offer_t2", int'(u_a.timer[2]), 24);
    chk("rst_offer_t3", int'(u_a.timer[3]), 28);
    chk("rst_offer_no_accept", acc_a - acc0, 0);

    rst_a = 1'b0;
    t0 = 0;
    p0 = 0;
    n = 0;
    while (!ifa.spawn_valid && n < 400) begin
      step();
      n++;
      if (n == 10) begin
        run_a = 1'b0;
        t0 = int'(u_a.timer[0]);
        p0 = int'(u_a.presc);
      end
      if (n == 110) begin
        chk("pause_timer_frozen", int'(u_a.timer[0]), t0);
        chk("pause_presc_frozen", int'(u_a.presc), p0);
        run_a = 1'b1;
      end
    end
    chk("pause_spawn_latency", n, 134);
    chk("pause_lane", int'(ifa.spawn_lane), 0);
  endtask

  task automatic seq_b();
    int n;
    n = 0;
    while (!ifb.spawn_valid && n < 1000) begin step(); n++; end
    chk("sat_spawn_latency", n, 502);
    chk("sat_lane", int'(ifb.spawn_lane), 0);
    chk("sat_len", int'(ifb.spawn_len), 0);
    step();
    chk("sat_accept_valid", int'(ifb.spawn_valid), 0);
    chk("sat_reload_timer0", int'(u_b.timer[0]), 255);
  endtask

  initial begin
    vecs[0] = '{pend: 4'b1011, last: 2'd1, grant: 2'd3, found: 1'b1};
    vecs[1] = '{pend: 4'b0011, last: 2'd3, grant: 2'd0, found: 1'b1};
    vecs[2] = '{pend: 4'b0010, last: 2'd0, grant: 2'd1, found: 1'b1};
    vecs[3] = '{pend: 4'b0000, last: 2'd2, grant: 2'd0, found: 1'b0};
    vecs[4] = '{pend: 4'b1111, last: 2'd3, grant: 2'd0, found: 1'b1};
    vecs[5] = '{pend: 4'b1111, last: 2'd0, grant: 2'd1, found: 1'b1};
    vecs[6] = '{pend: 4'b0001, last: 2'd0, grant: 2'd0, found: 1'b1};
    vecs[7] = '{pend: 4'b1000, last: 2'd2, grant: 2'd3, found: 1'b1};
    vecs[8] = '{pend: 4'b0100, last: 2'd3, grant: 2'd2, found: 1'b1};

    rst_a = 1'b1;
    rst_b = 1'b1;
    run_a = 1'b1;
    run_b = 1'b1;
    rnd_a = 14'h0105;
    rnd_b = 14'h00FF;
    ifa.spawn_ready = 1'b1;
    ifb.spawn_ready = 1'b1;

    for (int i = 0; i < 9; i++) begin
      rr_pend = vecs[i].pend;
      rr_last = vecs[i].last;
      #1;
      chk($sformatf("rr_found_%0d", i), int'(rr_found), int'(vecs[i].found));
      if (vecs[i].found) chk($sformatf("rr_grant_%0d", i), int'(rr_grant), int'(vecs[i].grant));
    end

    step();
    step();
    chk("reset_valid", int'(ifa.spawn_valid), 0);
    chk("reset_lane", int'(ifa.spawn_lane), 0);
    chk("reset_dir", int'(ifa.spawn_dir), 0);
    chk("reset_len", int'(ifa.spawn_len), 0);
    chk("reset_pending", int'(pend_a), 0);
    chk("reset_presc", int'(u_a.presc), 0);
    chk("reset_t0", int'(u_a.timer[0]), 16);
    chk("reset_t1", int'(u_a.timer[1]), 20);
    chk("reset_t2", int'(u_a.timer[2]), 24);
    chk("reset_t3", int'(u_a.timer[3]), 28);
    chk("reset_sat_t3", int'(u_b.timer[3]), 255);
    rst_a = 1'b0;
    rst_b = 1'b0;

    fork
      seq_a();
      seq_b();
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
